// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES arbiter/controller slice.
//   AES_W           : AES block width (plaintext, key, ciphertext).
//   TIMEOUT_CYC_DEF : default number of RUN cycles allowed before the job is
//                     reported as a timeout.
//   state_t         : controller FSM encoding.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_W           = 128;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // core parked, waiting for a request
        LOAD = 2'd1,   // operands presented, core held in reset for one cycle
        RUN  = 2'd2,   // core released and encrypting, counter running
        DONE = 2'd3    // result held until the consumer takes it
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational; the pointer
// moves only when the grant is actually taken.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset (requester 0 favoured after it)
//   i_req    : request vector, bit i = requester i
//   i_accept : the current grant is being taken this cycle
//   o_grant  : one-hot grant (zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // High when requester 1 was granted most recently. Resetting it high
    // means requester 0 wins the first contended grant.
    logic r_last1;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last1 ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last1 <= 1'b1;
        end else if (i_accept && (o_grant != 2'b00)) begin
            r_last1 <= o_grant[1];
        end
    end

endmodule

// File: rtl/aes_arb_ctrl.sv
// ---------------------------------------------------------------------------
// aes_arb_ctrl
// Shares one AES core between two requesters. A request is granted in IDLE,
// its operands are latched and presented to the core, the core is pulsed
// through reset (LOAD) and released (RUN), and the ciphertext -- or a timeout
// error -- is held for the consumer (DONE).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   req_valid / req_ready    : per-requester request handshake (bit i = req i)
//   req_data0/1, req_key0/1  : plaintext and key of each requester
//   rsp_valid / rsp_ready    : response handshake
//   rsp_data, rsp_id, rsp_err: ciphertext (zero on error), owner, timeout flag
//   core_data_in, core_key_in: operands to the core, stable LOAD..RUN
//   core_rst                 : active-high core reset; release starts the core
//   core_out_data, core_ready: core ciphertext and done flag
// ---------------------------------------------------------------------------
module aes_arb_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [AES_W-1:0] req_data0,
    input  logic [AES_W-1:0] req_data1,
    input  logic [AES_W-1:0] req_key0,
    input  logic [AES_W-1:0] req_key1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [AES_W-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [AES_W-1:0] core_data_in,
    output logic [AES_W-1:0] core_key_in,
    output logic             core_rst,
    input  logic [AES_W-1:0] core_out_data,
    input  logic             core_ready
);

    // Counter value in the last RUN cycle the core is allowed; the counter
    // is 0 in the first RUN cycle, so this gives TIMEOUT_CYC RUN cycles.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AES_W-1:0]   r_data;
    logic [AES_W-1:0]   r_key;
    logic               r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [AES_W-1:0]   r_rsp_data;
    logic               r_rsp_err;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_core_done;
    logic               w_timeout;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_core_done = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: w_state_nxt = RUN;
            RUN: begin
                // A ready seen in the first RUN cycle may be left over from
                // the previous job, so it is not trusted.
                w_core_done = core_ready && (r_cnt != '0);
                w_timeout   = (r_cnt == TIMEOUT_LAST);
                if (w_core_done || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, operand, counter and response registers
    // ------------------------------------------------------------------
    // NOTE: all registers here are plain flops, so each is given a reset
    // value; an abandoned job must leave nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_key      <= '0;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_grant[1];
                        r_data <= w_grant[1] ? req_data1 : req_data0;
                        r_key  <= w_grant[1] ? req_key1  : req_key0;
                    end
                end
                LOAD: r_cnt <= '0;
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // core_ready takes precedence over a coincident timeout.
                    if (w_core_done) begin
                        r_rsp_data <= core_out_data;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The grant is only offered in IDLE; rst gates it so req_ready is forced
    // low while reset is held even though IDLE is the reset state.
    assign req_ready    = (rst && (r_state == IDLE)) ? w_grant : 2'b00;
    assign rsp_valid    = (r_state == DONE);
    assign rsp_data     = r_rsp_data;
    assign rsp_id       = r_id;
    assign rsp_err      = r_rsp_err;
    assign core_data_in = r_data;
    assign core_key_in  = r_key;
    // The core stays parked in reset while idle and for the LOAD cycle.
    assign core_rst     = (r_state == IDLE) || (r_state == LOAD);

endmodule

// File: tb/tb_aes_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_arb_ctrl
// Self-checking bench for aes_arb_ctrl: directed scenarios followed by
// randomized jobs, checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_aes_arb_ctrl;
    import aes_pkg::*;

    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [AES_W-1:0] req_data0, req_data1, req_key0, req_key1;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [AES_W-1:0] rsp_data, core_data_in, core_key_in, core_out_data;
    logic             core_rst, core_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester model: a pending request holds valid with fixed operands.
    bit               pend [2];
    logic [AES_W-1:0] pdata [2];
    logic [AES_W-1:0] pkey [2];
    bit               last_gnt;   // model: requester 1 granted most recently
    int               seen_id;    // rsp_id observed on the latest response

    // Core model: counts RUN cycles since release, ready from cycle lat_v.
    int lat_v;
    int core_n;

    always #5 clk = ~clk;

    assign req_valid = {pend[1], pend[0]};
    assign req_data0 = pdata[0];
    assign req_data1 = pdata[1];
    assign req_key0  = pkey[0];
    assign req_key1  = pkey[1];

    function automatic logic [AES_W-1:0] core_fn(input logic [AES_W-1:0] d,
                                                 input logic [AES_W-1:0] k,
                                                 input int n);
        // Output depends on the cycle index so a mistimed capture shows up.
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_1234_5678_9abc_def0_0f0f_a5a5
               ^ AES_W'(n);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst)          core_n <= 0;
        else if (core_rst) core_n <= 0;
        else               core_n <= core_n + 1;
    end
    assign core_ready    = !core_rst && (core_n >= lat_v);
    assign core_out_data = core_fn(core_data_in, core_key_in, core_n);

    aes_arb_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data0     (req_data0),
        .req_data1     (req_data1),
        .req_key0      (req_key0),
        .req_key1      (req_key1),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .rsp_err       (rsp_err),
        .core_data_in  (core_data_in),
        .core_key_in   (core_key_in),
        .core_rst      (core_rst),
        .core_out_data (core_out_data),
        .core_ready    (core_ready)
    );

    task automatic check(input string tag, input logic [AES_W-1:0] got,
                         input logic [AES_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_rsp_id"},    rsp_id, 0);
        check({tag, "_rsp_err"},   rsp_err, 0);
        check({tag, "_core_rst"},  core_rst, 1);
        check({tag, "_core_data"}, core_data_in, 0);
        check({tag, "_core_key"},  core_key_in, 0);
    endtask

    task automatic make_pending(input int i);
        pend[i]  = 1'b1;
        pdata[i] = {$urandom, $urandom, $urandom, $urandom};
        pkey[i]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic random_pending();
        for (int i = 0; i < 2; i++)
            if (!pend[i] && ($urandom_range(0, 1) == 1)) make_pending(i);
        if (!pend[0] && !pend[1]) make_pending(int'($urandom_range(0, 1)));
    endtask

    // Reset asserted mid-cycle, released on a falling edge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst      = 1'b1;
        last_gnt = 1'b1;
    endtask

    // One complete job starting in IDLE (called just after a falling edge,
    // with at least one request pending). bp = cycles of response stall.
    task automatic do_job(input int lat, input int bp, input bit mid_rst);
        int               exp_id, m, exp_run, run;
        bit               exp_err, stable_ok;
        logic [AES_W-1:0] ed, ek, exp_data;
        logic [AES_W+2:0] snap;

        lat_v = lat;
        #1;
        if (pend[0] && pend[1]) exp_id = last_gnt ? 0 : 1;
        else                    exp_id = pend[1] ? 1 : 0;
        check("grant", req_ready, 2'b01 << exp_id);
        last_gnt = exp_id[0];
        ed = pdata[exp_id];
        ek = pkey[exp_id];

        @(negedge clk);                  // LOAD
        pend[exp_id] = 1'b0;
        #1;
        check("load_core_rst",  core_rst, 1);
        check("load_req_ready", req_ready, 0);
        check("load_core_data", core_data_in, ed);
        check("load_core_key",  core_key_in, ek);

        @(negedge clk); #1;              // first RUN cycle
        check("run_core_rst", core_rst, 0);

        m        = (lat < 1) ? 1 : lat;
        exp_err  = (m > TO - 1);
        exp_run  = exp_err ? TO : m + 1;
        exp_data = exp_err ? '0 : core_fn(ed, ek, m);

        run       = 0;
        stable_ok = 1'b1;
        while (!rsp_valid && run < 300) begin
            run++;
            if (core_data_in !== ed || core_key_in !== ek || req_ready !== 2'b00)
                stable_ok = 1'b0;
            if (mid_rst && run == 5) begin
                apply_reset("midrun");
                check("midrun_no_rsp", rsp_valid, 0);
                return;
            end
            @(negedge clk); #1;
        end
        check("run_stable", stable_ok, 1);
        check("run_length", run, exp_run);
        check("rsp_id",   rsp_id, exp_id);
        check("rsp_err",  rsp_err, exp_err);
        check("rsp_data", rsp_data, exp_data);
        seen_id = int'(rsp_id);

        // New requests arrive while the response is held; none may be granted.
        random_pending();
        snap = {rsp_valid, rsp_id, rsp_err, rsp_data};
        for (int c = 0; c < bp; c++) begin
            @(negedge clk); #1;
            check("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_data}, snap);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        rst       = 1'b0;
        rsp_ready = 1'b0;
        lat_v     = 1000;
        last_gnt  = 1'b1;
        seen_id   = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
            pkey[i]  = '0;
        end
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single request with the reference operand.
        pend[0]  = 1'b1;
        pdata[0] = 128'h0c0d0e0f08090a0b0405060700010203;
        pkey[0]  = 128'h0c0d0e0f08090a0b0405060700010203;
        do_job(10, 0, 1'b0);
        check("single_id", seen_id, 0);

        // Contention from a fresh reset: grants alternate starting at 0.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply_reset("reset2");
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) if (!pend[i]) make_pending(i);
            do_job(int'($urandom_range(1, 12)), 0, 1'b0);
            check("contention_order", seen_id, k % 2);
        end

        // Backpressure, timeout then normal job, stale ready, tie, timeout.
        random_pending(); do_job(3, 5, 1'b0);
        random_pending(); do_job(100000, 0, 1'b0);
        random_pending(); do_job(4, 0, 1'b0);
        random_pending(); do_job(0, 1, 1'b0);
        random_pending(); do_job(TO - 1, 0, 1'b0);
        random_pending(); do_job(TO, 0, 1'b0);

        // Reset in the middle of RUN, then a normal job.
        random_pending(); do_job(20, 0, 1'b1);
        random_pending(); do_job(7, 2, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            random_pending();
            if ($urandom_range(0, 7) == 0)
                do_job(int'($urandom_range(TO - 3, TO + 3)), int'($urandom_range(0, 3)), 1'b0);
            else
                do_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_arb_ctrl.md
AES_ARB_CTRL -- requirements
Module: aes_arb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum core cycles allowed from core release to core_ready.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the timeout counter width; 2^CNT_W SHALL exceed TIMEOUT_CYC.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester acceptance; bit i high in the cycle that requester i's request is taken.
REQ-007 req_data0, req_data1  in  128 each  plaintext of requester 0 and requester 1.
REQ-008 req_key0, req_key1  in  128 each  cipher key of requester 0 and requester 1.
REQ-009 rsp_valid  out  1  a result is held for the consumer.
REQ-010 rsp_ready  in  1  consumer accepts the result.
REQ-011 rsp_data  out  128  ciphertext, zero on error.
REQ-012 rsp_id  out  1  index of the requester that owns the result.
REQ-013 rsp_err  out  1  result is a timeout, not a ciphertext.
REQ-014 core_data_in, core_key_in  out  128 each  operands driven to the shared AES core.
REQ-015 core_rst  out  1  active-high core reset/start; the core begins encrypting on its release.
REQ-016 core_out_data  in  128  core ciphertext.
REQ-017 core_ready  in  1  core done flag.

Function
REQ-018 SHALL implement the FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-019 IDLE: if any req_valid bit is set, grant one requester round-robin, pulse its req_ready for 1 cycle, latch its data, key and id into operand registers, then go to LOAD.
REQ-020 Round-robin: the requester not granted most recently SHALL win when both are valid; after reset, requester 0 has priority.
REQ-021 A lone valid requester SHALL be granted regardless of the pointer.
REQ-022 LOAD: core_rst=1 for exactly 1 cycle with core_data_in/core_key_in stable; then go to RUN and clear the counter.
REQ-023 core_data_in/core_key_in SHALL remain stable from LOAD until leaving RUN.
REQ-024 RUN: core_rst=0; the counter increments every cycle.
REQ-025 RUN: core_ready is ignored in the first RUN cycle (stale-ready guard).
REQ-026 RUN, core_ready=1 thereafter: capture core_out_data into rsp_data, set rsp_err=0, go to DONE.
REQ-027 RUN, counter reaches TIMEOUT_CYC with no core_ready: rsp_data=0, rsp_err=1, go to DONE.
REQ-028 If core_ready and timeout occur in the same cycle, core_ready SHALL win.
REQ-029 DONE: rsp_valid=1; rsp_data, rsp_id and rsp_err stable until rsp_ready.
REQ-030 DONE with rsp_ready=1: go to IDLE next cycle; rsp_valid drops.
REQ-031 No new grant SHALL occur outside IDLE; req_ready SHALL be 0 outside IDLE.
REQ-032 Requests arriving while busy SHALL wait without loss, since the requester holds req_valid.
REQ-033 Throughput SHALL be 1 request per (1 IDLE + 1 LOAD + RUN length + DONE length) cycles.
REQ-034 core_rst SHALL be 1 in IDLE, keeping the core parked.

Reset
REQ-035 rst low SHALL asynchronously force: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, core_rst=1, operands=0, counter=0, round-robin pointer favouring requester 0.
REQ-036 Reset mid-RUN or mid-DONE SHALL discard the in-flight job with no response emitted; the requester must re-request.

Structure
REQ-037 A shared package aes_pkg SHALL hold: the FSM state encoding (IDLE, LOAD, RUN, DONE), the AES block width constant 128, and the default TIMEOUT_CYC.
REQ-038 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2-bit request in, 2-bit one-hot grant out, pointer update on accept).
REQ-039 The FSM, counter and registers SHALL reside in aes_arb_ctrl.

Verification
REQ-040 Single request: req_valid=01, data=key=0c0d0e0f08090a0b0405060700010203, core model ready after 10 cycles -> one req_ready pulse; rsp_valid with rsp_id=0, rsp_err=0, rsp_data equal to the core output; core_rst high for exactly 1 cycle after grant.
REQ-041 Contention: both valid continuously for 4 jobs -> grant order 0,1,0,1; each rsp_id matches.
REQ-042 Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_* stable; no req_ready pulses until accepted.
REQ-043 Timeout: core never ready, TIMEOUT_CYC=64 -> rsp_err=1, rsp_data=0 exactly 64 RUN cycles after release; the next job proceeds normally.
REQ-044 Stale/tie: core_ready high in the first RUN cycle is ignored; core_ready coincident with the timeout -> rsp_err=0.
REQ-045 Reset mid-RUN: assert rst low asynchronously -> outputs at reset values immediately, no response emitted; a subsequent request completes normally.
